// File: rtl/shift_reg_piso.sv
// rtl/shift_reg_piso.sv - parallel-in serial-out shift register with one-word holding buffer
//
// Accepts W-bit words over a valid/ready handshake and emits them one bit per
// accepted shift strobe, flagging the first and last bit of each word. A
// one-word holding buffer lets consecutive words stream with no idle bit.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   synchronous active-high reset
//   d           in   W-bit parallel word
//   load_valid  in   d is valid
//   load_ready  out  block can accept d this cycle
//   shift_en    in   consume the current serial bit
//   sout        out  current serial bit (0 when not valid)
//   sout_valid  out  sout holds a real bit
//   sout_first  out  current bit is bit 0 of the word
//   sout_last   out  current bit is bit W-1 of the word
//   busy        out  a bit is being presented or a word is held
module shift_reg_piso #(
  parameter int W         = 4,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic         shift_en,
  output logic         sout,
  output logic         sout_valid,
  output logic         sout_first,
  output logic         sout_last,
  output logic         busy
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t         state;
  logic [W-1:0]   sreg;
  logic [W-1:0]   hold;
  logic           hold_full;
  logic [CW-1:0]  cnt;

  logic accept;
  logic consume;
  logic last_consume;

  // Readiness only depends on the holding buffer: while a word is shifting,
  // the next one can always be parked in hold.
  assign load_ready   = !hold_full && !reset;
  assign accept       = load_valid && load_ready;
  assign sout_valid   = (state == SHIFT);
  assign consume      = sout_valid && shift_en;
  assign last_consume = consume && (cnt == CNT_LAST);

  assign sout       = sout_valid && (LSB_FIRST ? sreg[0] : sreg[W-1]);
  assign sout_first = sout_valid && (cnt == '0);
  assign sout_last  = sout_valid && (cnt == CNT_LAST);
  assign busy       = sout_valid || hold_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sreg      <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Holding buffer is always empty in IDLE, so load straight into sreg.
          if (accept) begin
            sreg  <= d;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (last_consume) begin
            if (hold_full) begin
              sreg      <= hold;
              cnt       <= '0;
              hold_full <= 1'b0;
            end else if (accept) begin
              sreg <= d;
              cnt  <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            if (consume) begin
              sreg <= LSB_FIRST ? (sreg >> 1) : (sreg << 1);
              cnt  <= cnt + CW'(1);
            end
            if (accept) begin
              hold      <= d;
              hold_full <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/shift_reg_piso.md
# shift_reg_piso

Parallel-in serial-out shift register: the transmit-side companion to the team's parallel and serial-in capture registers. It accepts W-bit words over a valid/ready handshake and emits them one bit per accepted shift strobe, with first/last-bit framing flags. A one-word holding buffer lets back-to-back words stream with no idle bit between them.

## Interface
- W, 4: word width in bits; W >= 1.
- LSB_FIRST, 0: 0 = MSB transmitted first; 1 = LSB transmitted first.

- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high; clears all state on the rising edge where it is sampled high.
- d  in  W  parallel word to transmit.
- load_valid  in  1  d is valid.
- load_ready  out  1  block can accept d this cycle.
- shift_en  in  1  serial-side strobe; the current bit is consumed on an edge where sout_valid && shift_en.
- sout  out  1  current serial bit; 0 when sout_valid = 0.
- sout_valid  out  1  sout holds a real bit.
- sout_first  out  1  sout_valid && current bit is bit 0 of the word.
- sout_last  out  1  sout_valid && current bit is bit W-1 of the word.
- busy  out  1  sout_valid || holding buffer full.

## Operation
- State: shifter sreg[W-1:0], bit counter cnt (width max(1, clog2(W))), holding buffer hold[W-1:0], flag hold_full, state IDLE/SHIFT. sout_valid = (state == SHIFT).
- Reset values: sreg = 0, cnt = 0, hold = 0, hold_full = 0, state = IDLE. Every output is 0 while reset is high; load_ready = 1 on the first cycle after reset deasserts.
- load_ready = !hold_full && !reset (combinational). Accept = load_valid && load_ready.
- sout = sreg[W-1] when LSB_FIRST = 0, sreg[0] when LSB_FIRST = 1, gated by sout_valid.
- Consume = sout_valid && shift_en. The last bit is consumed when Consume && cnt == W-1.
- IDLE:
  - Accept → sreg <= d, cnt <= 0, state <= SHIFT. Bypasses the holding buffer.
  - No accept → stay in IDLE.
- SHIFT, consume of a non-last bit: shift sreg toward the output end (left for MSB-first, right for LSB-first; fill with 0), cnt <= cnt + 1.
- SHIFT, consume of the last bit, checked in this priority:
  - hold_full → sreg <= hold, cnt <= 0, hold_full <= 0, stay in SHIFT.
  - else Accept → sreg <= d, cnt <= 0, stay in SHIFT (direct load, no gap).
  - else → state <= IDLE.
- SHIFT, any cycle other than a last-bit consume: Accept → hold <= d, hold_full <= 1.
- A word is never dropped, duplicated or reordered. A stalled bit (shift_en low) holds sout, cnt and the flags stable.
- W = 1: every bit is both first and last. sout_first = sout_last = 1 whenever sout_valid = 1.
- Reset mid-word discards the partial word and the held word. Nothing resumes after reset.

## Timing
- Latency: word accepted in IDLE at edge N → bit 0 on sout during cycle N+1.
- Throughput: one bit per cycle with shift_en held high. Consecutive words are contiguous when the next word is held or accepted by the last-bit edge.
- load_ready drops the cycle after a word enters the holding buffer. It returns the cycle after the hold→sreg transfer.
- All outputs except load_ready are registered or derived only from registered state. load_ready depends combinationally on reset.

## Test plan
- W=4, MSB-first, accept 4'b1011 from idle, shift_en=1 → sout = 1,0,1,1 in cycles N+1..N+4; sout_first only at N+1; sout_last only at N+4; sout_valid=0 and busy=0 at N+5.
- Back-to-back: 4'hA accepted at edge 0, 4'h5 at edge 1, shift_en=1 → 8 contiguous valid bits 1,0,1,0,0,1,0,1 in cycles 1-8; load_ready = 0 during cycles 2-4 and 1 at cycle 5.
- Stall: 4'b1100 with shift_en = 1,0,0,1,1,0,1 → each bit holds for the full stall; order is 1,1,0,0; sout_last is high exactly once, and only with the final bit.
- LSB_FIRST=1, 4'b1011 → sout = 1,1,0,1; sout_first/sout_last timing is the same as the MSB-first case.
- Reset mid-frame: 4'hF in flight, 4'h3 held, reset pulsed after 2 bits → the next cycle shows sout_valid=0, busy=0, load_ready=1. A new word 4'h9 then transmits 1,0,0,1 starting with sout_first, with no residue from 4'hF or 4'h3.
- W=1: alternating words 1,0,1 with load_valid and shift_en held high → sout = 1,0,1 on consecutive cycles, with sout_first = sout_last = 1 on every valid cycle.
